// File: rtl/acq_trigger.sv
// acq_trigger: trigger front-end for the acquisition path.
//   Arms on a host request, watches the ADC stream for a threshold crossing on
//   the selected edge, then grants the RAM-writing stage until it reports done.
//   Scope mode forwards raw samples every cycle. Logic-analyser mode thresholds
//   each sample to one bit and packs 8 bits per output byte, LSB first.
// Optional feature: define ACQ_TRIG_TIMEOUT_EN to force a trigger after
//   TIMEOUT_CYCLES armed cycles without an edge. When it is undefined there is
//   no counter and auto_trig is tied 0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   adc_data          raw sample, new value every cycle
//   arm, abort        host arm request / cancel back to IDLE
//   mode              0 scope, 1 logic analyser        (latched at arm)
//   trig_edge         0 falling, 1 rising              (latched at arm)
//   threshold         trigger level / LA bit threshold (latched at arm)
//   done_acq          acquisition stage finished (RAM full)
//   grant_acq         acquisition stage may write
//   smp_data/valid    sample or packed byte toward RAM, with its strobe
//   armed             waiting for a trigger
//   capture_done      one-cycle pulse on normal capture end
//   auto_trig         last trigger came from the timeout
module acq_trigger #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              mode,
  input  logic              trig_edge,
  input  logic [DATA_W-1:0] threshold,
  input  logic              done_acq,
  output logic              grant_acq,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  output logic              armed,
  output logic              capture_done,
  output logic              auto_trig
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] adc_q, thr_q;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic              mode_q, edge_q, lvl, lvl_prev, seed;
  logic              edge_hit, timeout_hit, fire, arm_acc;

  assign lvl      = (adc_q >= thr_q);
  assign arm_acc  = (state == IDLE) && arm && !abort;
  // seed masks the first armed cycle: lvl_prev still reflects the old threshold
  assign edge_hit = (state == ARMED) && !seed &&
                    (edge_q ? (!lvl_prev && lvl) : (lvl_prev && !lvl));
  assign fire     = edge_hit || timeout_hit;

`ifdef ACQ_TRIG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state == ARMED) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // counter sits at 0 outside ARMED, so it is clear on every entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   to_cnt <= '0;
    else if (state != ARMED)   to_cnt <= '0;
    else                       to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       auto_trig <= 1'b0;
    else if (arm_acc)                              auto_trig <= 1'b0;
    else if (!abort && timeout_hit && !edge_hit)   auto_trig <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
  assign auto_trig      = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; abort wins over everything
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (arm)      state_nxt = ARMED;
        ARMED:   if (fire)     state_nxt = RUN;
        RUN:     if (done_acq) state_nxt = IDLE;
        default:               state_nxt = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    grant_acq = (state == RUN);
    armed     = (state == ARMED);
  end

  // sample pipeline, config latch and capture datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_q        <= '0;
      lvl_prev     <= 1'b0;
      thr_q        <= '0;
      mode_q       <= 1'b0;
      edge_q       <= 1'b0;
      seed         <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      smp_data     <= '0;
      smp_valid    <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      adc_q        <= adc_data;
      lvl_prev     <= lvl;
      smp_valid    <= 1'b0;
      capture_done <= 1'b0;
      if (abort) begin
        bit_cnt <= '0;
        seed    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm) begin
            thr_q  <= threshold;
            mode_q <= mode;
            edge_q <= trig_edge;
            seed   <= 1'b1;
          end
          ARMED: begin
            seed <= 1'b0;
            if (fire) begin
              // the trigger sample is the first sample of the capture
              if (!mode_q) begin
                smp_data  <= adc_q;
                smp_valid <= 1'b1;
              end else begin
                shreg   <= {7'd0, lvl};
                bit_cnt <= 3'd1;
              end
            end
          end
          RUN: begin
            if (done_acq) begin
              capture_done <= 1'b1;
              bit_cnt      <= '0;   // partial LA byte is dropped
            end else if (!mode_q) begin
              smp_data  <= adc_q;
              smp_valid <= 1'b1;
            end else begin
              shreg[bit_cnt] <= lvl;
              bit_cnt        <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                smp_data  <= DATA_W'({lvl, shreg[6:0]});
                smp_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
